// File: rtl/slurm32_cpu_pkg.sv
// Shared constants for the slurm32 CPU pipeline: default widths and ALU opcodes.
package slurm32_cpu_pkg;

    localparam int unsigned DEF_BITS     = 32;
    localparam int unsigned DEF_REG_BITS = 4;
    localparam int unsigned DEF_IMM_BITS = 16;
    localparam int unsigned ALU_OP_BITS  = 5;

    localparam logic [ALU_OP_BITS-1:0] ALU_OP_MOV = 5'd0;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_ADD = 5'd1;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_ADC = 5'd2;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_SUB = 5'd3;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_SBB = 5'd4;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_AND = 5'd5;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_OR  = 5'd6;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_XOR = 5'd7;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_NOP = 5'd31;

endpackage

// File: rtl/slurm32_cpu_fwd_mux.sv
// Operand forwarding select for one source: r0, ALU result, writeback bus, then register file.
module slurm32_cpu_fwd_mux #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned REG_BITS = 4
) (
    input  logic [REG_BITS-1:0] idx,
    input  logic [BITS-1:0]     rfData,
    input  logic                s2Valid,
    input  logic [REG_BITS-1:0] s2Rd,
    input  logic [BITS-1:0]     aluOut,
    input  logic                wbValid,
    input  logic [REG_BITS-1:0] wbRd,
    input  logic [BITS-1:0]     wbData,
    output logic [BITS-1:0]     fwdData_c
);

    // Priority select: the youngest in-flight producer wins over older ones.
    always_comb begin
        fwdData_c = rfData;
        if (idx == '0)
            fwdData_c = '0;
        else if (s2Valid && (s2Rd == idx))
            fwdData_c = aluOut;
        else if (wbValid && (wbRd == idx))
            fwdData_c = wbData;
    end

endmodule

// File: rtl/slurm32_cpu_operand_stage.sv
// Issue/operand stage: hazard detect, operand forwarding, immediate prefix latch,
// and the destination-tag pipeline that runs alongside the ALU.
module slurm32_cpu_operand_stage
    import slurm32_cpu_pkg::*;
#(
    parameter int unsigned BITS     = DEF_BITS,
    parameter int unsigned REG_BITS = DEF_REG_BITS,
    parameter int unsigned IMM_BITS = DEF_IMM_BITS
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_is_prefix,
    input  logic [ALU_OP_BITS-1:0] in_op,
    input  logic [REG_BITS-1:0]    in_rd,
    input  logic                   in_wr,
    input  logic [REG_BITS-1:0]    in_ra,
    input  logic [REG_BITS-1:0]    in_rb,
    input  logic                   in_use_a,
    input  logic                   in_use_imm,
    input  logic [IMM_BITS-1:0]    in_imm,
    input  logic [BITS-1:0]        rf_a,
    input  logic [BITS-1:0]        rf_b,
    input  logic [BITS-1:0]        alu_out,
    input  logic                   wb_valid,
    input  logic [REG_BITS-1:0]    wb_rd,
    input  logic [BITS-1:0]        wb_data,
    input  logic                   stall_in,
    input  logic                   flush_in,
    output logic [BITS-1:0]        alu_A,
    output logic [BITS-1:0]        alu_B,
    output logic [ALU_OP_BITS-1:0] alu_op,
    output logic                   res_valid,
    output logic [REG_BITS-1:0]    res_rdest
);

    // s1 tag: instruction currently sitting in alu_A/alu_B/alu_op.
    logic                s1Valid;
    logic [REG_BITS-1:0] s1Rd;
    // Pending upper immediate from a prefix instruction.
    logic                pfxValid;
    logic [IMM_BITS-1:0] pfxHi;

    logic                hazard_c;
    logic                accept_c;
    logic                issue_c;
    logic [BITS-1:0]     fwdA_c;
    logic [BITS-1:0]     fwdB_c;
    logic [BITS-1:0]     imm_c;

    // Distance-1 dependence cannot be forwarded; hold the consumer for one bubble.
    always_comb begin
        hazard_c = 1'b0;
        if (in_valid && !in_is_prefix && s1Valid && (s1Rd != '0)) begin
            if ((in_use_a && (in_ra == s1Rd)) || (!in_use_imm && (in_rb == s1Rd)))
                hazard_c = 1'b1;
        end
    end

    assign in_ready = !stall_in && !flush_in && !hazard_c;
    assign accept_c = in_valid && in_ready;
    assign issue_c  = accept_c && !in_is_prefix;

    // Immediate: prefix supplies the upper half, otherwise sign-extend the field.
    always_comb begin
        imm_c = {{(BITS-IMM_BITS){in_imm[IMM_BITS-1]}}, in_imm};
        if (pfxValid)
            imm_c = BITS'({pfxHi, in_imm});
    end

    slurm32_cpu_fwd_mux #(.BITS(BITS), .REG_BITS(REG_BITS)) u_fwdA (
        .idx       (in_ra),
        .rfData    (rf_a),
        .s2Valid   (res_valid),
        .s2Rd      (res_rdest),
        .aluOut    (alu_out),
        .wbValid   (wb_valid),
        .wbRd      (wb_rd),
        .wbData    (wb_data),
        .fwdData_c (fwdA_c)
    );

    slurm32_cpu_fwd_mux #(.BITS(BITS), .REG_BITS(REG_BITS)) u_fwdB (
        .idx       (in_rb),
        .rfData    (rf_b),
        .s2Valid   (res_valid),
        .s2Rd      (res_rdest),
        .aluOut    (alu_out),
        .wbValid   (wb_valid),
        .wbRd      (wb_rd),
        .wbData    (wb_data),
        .fwdData_c (fwdB_c)
    );

    // Operand registers, tag pipeline and prefix latch; bubbles issue NOP so no op re-executes.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            alu_A     <= '0;
            alu_B     <= '0;
            alu_op    <= ALU_OP_NOP;
            s1Valid   <= 1'b0;
            s1Rd      <= '0;
            res_valid <= 1'b0;
            res_rdest <= '0;
            pfxValid  <= 1'b0;
            pfxHi     <= '0;
        end else begin
            res_valid <= s1Valid;
            res_rdest <= s1Rd;
            if (issue_c) begin
                alu_A    <= fwdA_c;
                alu_B    <= in_use_imm ? imm_c : fwdB_c;
                alu_op   <= in_op;
                s1Valid  <= in_wr;
                s1Rd     <= in_rd;
                pfxValid <= 1'b0;
            end else begin
                alu_op  <= ALU_OP_NOP;
                s1Valid <= 1'b0;
                if (flush_in) begin
                    pfxValid <= 1'b0;
                end else if (accept_c) begin
                    pfxValid <= 1'b1;
                    pfxHi    <= in_imm;
                end
            end
        end
    end

endmodule

// File: tb/tb_slurm32_cpu_operand_stage.sv
// Scoreboard bench for slurm32_cpu_operand_stage with a tiny MOV/ADD ALU model.
module tb_slurm32_cpu_operand_stage;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        in_valid, in_ready, in_is_prefix, in_wr, in_use_a, in_use_imm;
    logic [4:0]  in_op;
    logic [3:0]  in_rd, in_ra, in_rb;
    logic [15:0] in_imm;
    logic [31:0] rf_a, rf_b, alu_out, wb_data;
    logic        wb_valid, stall_in, flush_in;
    logic [3:0]  wb_rd;
    logic [31:0] alu_A, alu_B;
    logic [4:0]  alu_op;
    logic        res_valid;
    logic [3:0]  res_rdest;

    localparam logic [4:0] OP_MOV = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_NOP = 5'd31;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
    } opExp_t;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } resExp_t;

    opExp_t  expOps[$];
    resExp_t expRes[$];
    opExp_t  eOp;
    resExp_t eRes;
    int      nChecks = 0;
    int      nPass   = 0;

    slurm32_cpu_operand_stage dut (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_prefix (in_is_prefix),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_wr        (in_wr),
        .in_ra        (in_ra),
        .in_rb        (in_rb),
        .in_use_a     (in_use_a),
        .in_use_imm   (in_use_imm),
        .in_imm       (in_imm),
        .rf_a         (rf_a),
        .rf_b         (rf_b),
        .alu_out      (alu_out),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_in     (stall_in),
        .flush_in     (flush_in),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_op       (alu_op),
        .res_valid    (res_valid),
        .res_rdest    (res_rdest)
    );

    always #5 CLK = ~CLK;

    // Minimal registered ALU: only what the stimulus uses.
    initial alu_out = 32'd0;
    always @(posedge CLK) begin
        case (alu_op)
            OP_MOV:  alu_out <= alu_B;
            OP_ADD:  alu_out <= alu_A + alu_B;
            default: ;
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            nPass++;
    endfunction

    // Monitor: every issued op and every tagged result is popped and compared.
    always @(negedge CLK) begin
        if (RSTb === 1'b1) begin
            if (alu_op !== OP_NOP) begin
                if (expOps.size() == 0) begin
                    nChecks++;
                    $display("FAIL unexpected_op: got op=%0d A=0x%08h B=0x%08h expected none", alu_op, alu_A, alu_B);
                end else begin
                    eOp = expOps.pop_front();
                    chk("op_A", alu_A, eOp.a);
                    chk("op_B", alu_B, eOp.b);
                    chk("op_code", 32'(alu_op), 32'(eOp.op));
                end
            end
            if (res_valid === 1'b1) begin
                if (expRes.size() == 0) begin
                    nChecks++;
                    $display("FAIL unexpected_res: got rdest=%0d data=0x%08h expected none", res_rdest, alu_out);
                end else begin
                    eRes = expRes.pop_front();
                    chk("res_rdest", 32'(res_rdest), 32'(eRes.rd));
                    chk("res_data", alu_out, eRes.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic pfx, input logic [4:0] op, input logic [3:0] rd,
                         input logic wr, input logic [3:0] ra, input logic [3:0] rb,
                         input logic ua, input logic ui, input logic [15:0] imm);
        in_valid = v; in_is_prefix = pfx; in_op = op; in_rd = rd; in_wr = wr;
        in_ra = ra; in_rb = rb; in_use_a = ua; in_use_imm = ui; in_imm = imm;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic expectOp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                            input logic [3:0] rd, input logic [31:0] data);
        expOps.push_back('{a: a, b: b, op: op});
        expRes.push_back('{rd: rd, data: data});
    endtask

    task automatic checkReady(input string name, input logic exp);
        #1;
        chk(name, 32'(in_ready), 32'(exp));
    endtask

    initial begin
        RSTb = 1'b0;
        drive(0, 0, 5'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'd0);
        rf_a = 0; rf_b = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        stall_in = 0; flush_in = 0;
        repeat (2) tick();

        // Reset state
        chk("rst_alu_A", alu_A, 32'd0);
        chk("rst_alu_B", alu_B, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_rdest", 32'(res_rdest), 32'd0);
        RSTb = 1'b1;
        checkReady("ready_after_reset", 1'b1);

        // Independent add r1,r2,r3
        rf_a = 32'd5; rf_b = 32'd7;
        drive(1, 0, OP_ADD, 4'd1, 1, 4'd2, 4'd3, 1, 0, 16'd0);
        checkReady("ready_indep", 1'b1);
        expectOp(32'd5, 32'd7, OP_ADD, 4'd1, 32'd12);
        tick();
        idle(3);

        // mov r1,#3 ; add r2,r1,r1 -> one bubble, both operands from alu_out
        drive(1, 0, OP_MOV, 4'd1, 1, 4'd0, 4'd0, 0, 1, 16'd3);
        expectOp(32'd0, 32'd3, OP_MOV, 4'd1, 32'd3);
        tick();
        rf_a = 32'd99; rf_b = 32'd99;
        drive(1, 0, OP_ADD, 4'd2, 1, 4'd1, 4'd1, 1, 0, 16'd0);
        checkReady("hazard_ready", 1'b0);
        tick();
        chk("hazard_bubble", 32'(alu_op), 32'(OP_NOP));
        chk("hazard_release", 32'(in_ready), 32'd1);
        expectOp(32'd3, 32'd3, OP_ADD, 4'd2, 32'd6);
        tick();
        idle(3);

        // Distance 3: wb_data beats stale rf, r0 operand reads zero
        rf_a = 32'd0; rf_b = 32'd55;
        wb_valid = 1; wb_rd = 4'd4; wb_data = 32'h0000_DEAD;
        drive(1, 0, OP_ADD, 4'd6, 1, 4'd4, 4'd0, 1, 0, 16'd0);
        expectOp(32'h0000_DEAD, 32'd0, OP_ADD, 4'd6, 32'h0000_DEAD);
        tick();
        wb_valid = 0;
        idle(3);

        // Distance 2: alu_out beats a simultaneous writeback to the same register
        drive(1, 0, OP_MOV, 4'd7, 1, 4'd0, 4'd0, 0, 1, 16'h0011);
        expectOp(32'd0, 32'h11, OP_MOV, 4'd7, 32'h11);
        tick();
        idle(1);
        wb_valid = 1; wb_rd = 4'd7; wb_data = 32'h99; rf_a = 32'h77;
        drive(1, 0, OP_ADD, 4'd8, 1, 4'd7, 4'd0, 1, 0, 16'd0);
        checkReady("dist2_ready", 1'b1);
        expectOp(32'h11, 32'd0, OP_ADD, 4'd8, 32'h11);
        tick();
        wb_valid = 0;
        idle(3);

        // Prefix 0x1234 then mov r5,#0x8000, then the same mov without prefix
        drive(1, 1, OP_MOV, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'h1234);
        checkReady("prefix_ready", 1'b1);
        tick();
        chk("prefix_slot", 32'(alu_op), 32'(OP_NOP));
        drive(1, 0, OP_MOV, 4'd5, 1, 4'd0, 4'd0, 0, 1, 16'h8000);
        expectOp(32'd0, 32'h1234_8000, OP_MOV, 4'd5, 32'h1234_8000);
        tick();
        expectOp(32'd0, 32'hFFFF_8000, OP_MOV, 4'd5, 32'hFFFF_8000);
        tick();
        idle(3);

        // Stall for three cycles after a prefix: NOPs issued, prefix retained
        drive(1, 0, OP_MOV, 4'd10, 1, 4'd0, 4'd0, 0, 1, 16'd7);
        expectOp(32'd0, 32'd7, OP_MOV, 4'd10, 32'd7);
        tick();
        drive(1, 1, OP_MOV, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'hABCD);
        tick();
        stall_in = 1;
        drive(1, 0, OP_MOV, 4'd9, 1, 4'd0, 4'd0, 0, 1, 16'h0001);
        checkReady("stall_ready", 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_nop", 32'(alu_op), 32'(OP_NOP));
        end
        stall_in = 0;
        expectOp(32'd0, 32'hABCD_0001, OP_MOV, 4'd9, 32'hABCD_0001);
        tick();
        idle(3);

        // Flush after a prefix: prefix discarded, sign extension used
        drive(1, 1, OP_MOV, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'h5555);
        tick();
        flush_in = 1;
        drive(1, 0, OP_MOV, 4'd11, 1, 4'd0, 4'd0, 0, 1, 16'h8001);
        checkReady("flush_ready", 1'b0);
        tick();
        chk("flush_nop", 32'(alu_op), 32'(OP_NOP));
        flush_in = 0;
        expectOp(32'd0, 32'hFFFF_8001, OP_MOV, 4'd11, 32'hFFFF_8001);
        tick();
        idle(3);

        // Reset with s1 and s2 both valid: s1's result must never appear
        drive(1, 0, OP_MOV, 4'd13, 1, 4'd0, 4'd0, 0, 1, 16'd1);
        expectOp(32'd0, 32'd1, OP_MOV, 4'd13, 32'd1);
        tick();
        drive(1, 0, OP_MOV, 4'd14, 1, 4'd0, 4'd0, 0, 1, 16'd2);
        expectOp(32'd0, 32'd2, OP_MOV, 4'd14, 32'd2);
        tick();
        in_valid = 0;
        @(negedge CLK);
        #1;
        RSTb = 1'b0;
        expRes.delete();
        tick();
        chk("rst_mid_op", 32'(alu_op), 32'(OP_NOP));
        chk("rst_mid_res", 32'(res_valid), 32'd0);
        RSTb = 1'b1;
        tick();
        chk("rst_no_stale", 32'(res_valid), 32'd0);
        chk("rst_idle_op", 32'(alu_op), 32'(OP_NOP));
        idle(3);

        chk("ops_drained", 32'(expOps.size()), 32'd0);
        chk("res_drained", 32'(expRes.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
